// File: rtl/instruction_fetch_unit_if.sv
// instruction_fetch_unit_if: instruction-memory fetch port, redirect input and decode-side handshake.
interface instruction_fetch_unit_if #(
    parameter int DEPTH = 2
);
    logic [31:0]            imem_address;
    logic [31:0]            imem_instruction;
    logic                   redirect;
    logic [31:0]            redirect_target;
    logic                   instr_valid;
    logic                   instr_ready;
    logic [31:0]            instruction;
    logic [31:0]            instr_pc;
    logic [31:0]            instr_pc_plus4;
    logic [$clog2(DEPTH):0] queue_count;

    modport master (
        output imem_address, instr_valid, instruction, instr_pc, instr_pc_plus4, queue_count,
        input  imem_instruction, redirect, redirect_target, instr_ready
    );
    modport slave (
        input  imem_address, instr_valid, instruction, instr_pc, instr_pc_plus4, queue_count,
        output imem_instruction, redirect, redirect_target, instr_ready
    );
endinterface

// File: rtl/instruction_fetch_unit.sv
// instruction_fetch_unit: PC owner feeding a small prefetch FIFO toward decode, flushed by redirects.
module instruction_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 2
) (
    input logic                      clk,
    input logic                      reset,
    instruction_fetch_unit_if.master bus
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH) + 1;

    logic [31:0]   pc;
    logic [31:0]   word_q [DEPTH];
    logic [31:0]   addr_q [DEPTH];
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;
    logic [CW-1:0] count;
    logic          valid;
    logic          pop;
    logic          push;

    assign valid = count != '0;
    assign pop   = valid & bus.instr_ready;
    assign push  = (count != CW'(DEPTH)) | pop;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc     <= RESET_PC & ~32'h3;
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (bus.redirect) begin
            pc     <= bus.redirect_target & ~32'h3;
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                pc     <= pc + 32'd4;
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            count <= count + CW'(push) - CW'(pop);
        end
    end

    // Storage needs no reset: the head outputs are masked to zero while empty.
    always_ff @(posedge clk) begin
        if (push && !bus.redirect) begin
            word_q[wr_ptr] <= bus.imem_instruction;
            addr_q[wr_ptr] <= pc;
        end
    end

    assign bus.imem_address   = pc;
    assign bus.instr_valid    = valid;
    assign bus.queue_count    = count;
    assign bus.instruction    = valid ? word_q[rd_ptr] : 32'h0;
    assign bus.instr_pc       = valid ? addr_q[rd_ptr] : 32'h0;
    assign bus.instr_pc_plus4 = valid ? addr_q[rd_ptr] + 32'd4 : 32'h0;
endmodule
